// File: rtl/lcd_pkg.sv
// Shared LCD pixel-pipeline definitions.
//   - rgb565_t           : packed RGB565 pixel
//   - SIGN_W / SIGN_H    : sign bitmap dimensions in pixels
//   - SIGN_LAST_ROW_BASE : ROM address of the first pixel of the last bitmap row
//   - FG_DEFAULT / BG_DEFAULT : colours used until the first frame_start_i
package lcd_pkg;

  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;

  localparam int SIGN_W             = 480;
  localparam int SIGN_H             = 272;
  localparam int SIGN_LAST_ROW_BASE = SIGN_W * (SIGN_H - 1);

  localparam rgb565_t FG_DEFAULT = rgb565_t'(16'hFFFF);
  localparam rgb565_t BG_DEFAULT = rgb565_t'(16'h0000);

endpackage

// File: rtl/sign_addr_gen.sv
// Sign window detection and ROM address generation.
// Holds the frame-shadowed enable/origin, compares the scan position against
// the sign window and produces the registered ROM address.
//   clk, rst_n              : clock, asynchronous active-low reset
//   frame_start_i           : loads shadows, restarts the row counter
//   pix_x_i, pix_y_i, de_i  : scan position and data enable
//   enable_i, org_x_i/org_y_i : live settings (sampled on frame_start_i)
//   rom_addr_o              : registered ROM address, holds on misses
//   hit_o                   : combinational window hit for the current pixel
module sign_addr_gen
  import lcd_pkg::*;
#(
  parameter int ADDR_WIDTH = 17,
  parameter int POS_WIDTH  = 10,
  parameter int SIGN_W     = lcd_pkg::SIGN_W,
  parameter int SIGN_H     = lcd_pkg::SIGN_H
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  frame_start_i,
  input  logic [POS_WIDTH-1:0]  pix_x_i,
  input  logic [POS_WIDTH-1:0]  pix_y_i,
  input  logic                  de_i,
  input  logic                  enable_i,
  input  logic [POS_WIDTH-1:0]  org_x_i,
  input  logic [POS_WIDTH-1:0]  org_y_i,
  output logic [ADDR_WIDTH-1:0] rom_addr_o,
  output logic                  hit_o
);

  // One extra bit so org + size can never wrap around the coordinate space.
  localparam logic [POS_WIDTH:0]    WIN_W    = (POS_WIDTH + 1)'(SIGN_W);
  localparam logic [POS_WIDTH:0]    WIN_H    = (POS_WIDTH + 1)'(SIGN_H);
  localparam logic [ADDR_WIDTH-1:0] ROW_STEP = ADDR_WIDTH'(SIGN_W);
  localparam logic [ADDR_WIDTH-1:0] ROW_LAST = ADDR_WIDTH'(SIGN_W * (SIGN_H - 1));

  logic                  enable_sh;
  logic [POS_WIDTH-1:0]  org_x_sh;
  logic [POS_WIDTH-1:0]  org_y_sh;
  logic [ADDR_WIDTH-1:0] row_base;
  logic                  row_hit;
  logic                  de_q;

  logic [POS_WIDTH:0]    x_ext, y_ext, ox_ext, oy_ext;
  logic                  in_x, in_y, de_fall;
  logic [ADDR_WIDTH-1:0] col_off;

  assign x_ext  = {1'b0, pix_x_i};
  assign y_ext  = {1'b0, pix_y_i};
  assign ox_ext = {1'b0, org_x_sh};
  assign oy_ext = {1'b0, org_y_sh};

  assign in_x = (x_ext >= ox_ext) && (x_ext < ox_ext + WIN_W);
  assign in_y = (y_ext >= oy_ext) && (y_ext < oy_ext + WIN_H);

  // A pixel coinciding with frame_start_i would use stale shadows: force a miss.
  assign hit_o   = enable_sh & de_i & in_x & in_y & ~frame_start_i;
  assign col_off = ADDR_WIDTH'(pix_x_i) - ADDR_WIDTH'(org_x_sh);
  assign de_fall = de_q & ~de_i;

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enable_sh  <= 1'b0;
      org_x_sh   <= '0;
      org_y_sh   <= '0;
      row_base   <= '0;
      row_hit    <= 1'b0;
      de_q       <= 1'b0;
      rom_addr_o <= '0;
    end else begin
      de_q <= de_i;
      if (frame_start_i) begin
        // Takes priority over a de_i falling edge in the same cycle.
        enable_sh <= enable_i;
        org_x_sh  <= org_x_i;
        org_y_sh  <= org_y_i;
        row_base  <= '0;
        row_hit   <= 1'b0;
      end else if (hit_o) begin
        rom_addr_o <= row_base + col_off;
        row_hit    <= 1'b1;
      end else if (de_fall && row_hit) begin
        // Advance only after a line that actually touched the window, so a
        // right/bottom clip never skews the row stride.
        row_base <= (row_base >= ROW_LAST) ? ROW_LAST : row_base + ROW_STEP;
        row_hit  <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/sign_bitmap_render.sv
// Renders a 1-bit sign bitmap into an RGB565 pixel stream.
// Fixed 3-cycle latency from pixel input to rgb_o / de_o / hs_o / vs_o.
//   clk, rst_n                  : clock, asynchronous active-low reset
//   frame_start_i               : frame boundary, loads all shadow settings
//   pix_x_i, pix_y_i            : scan coordinate (valid with de_i)
//   de_i, hs_i, vs_i            : timing-generator sidebands
//   enable_i, org_x_i, org_y_i  : sign window settings
//   fg_color_i, bg_color_i      : colours for bitmap bit 1 / bit 0 and outside
//   rom_addr_o, rom_data_i      : sign ROM port (1-cycle registered read)
//   rgb_o, de_o, hs_o, vs_o     : output pixel and aligned sidebands
module sign_bitmap_render
  import lcd_pkg::*;
#(
  parameter int ADDR_WIDTH  = 17,
  parameter int SIGN_W      = lcd_pkg::SIGN_W,
  parameter int SIGN_H      = lcd_pkg::SIGN_H,
  parameter int POS_WIDTH   = 10,
  parameter int COLOR_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   frame_start_i,
  input  logic [POS_WIDTH-1:0]   pix_x_i,
  input  logic [POS_WIDTH-1:0]   pix_y_i,
  input  logic                   de_i,
  input  logic                   hs_i,
  input  logic                   vs_i,
  input  logic                   enable_i,
  input  logic [POS_WIDTH-1:0]   org_x_i,
  input  logic [POS_WIDTH-1:0]   org_y_i,
  input  logic [COLOR_WIDTH-1:0] fg_color_i,
  input  logic [COLOR_WIDTH-1:0] bg_color_i,
  output logic [ADDR_WIDTH-1:0]  rom_addr_o,
  input  logic                   rom_data_i,
  output logic [COLOR_WIDTH-1:0] rgb_o,
  output logic                   de_o,
  output logic                   hs_o,
  output logic                   vs_o
);

  localparam logic [COLOR_WIDTH-1:0] FG_RST = COLOR_WIDTH'(FG_DEFAULT);
  localparam logic [COLOR_WIDTH-1:0] BG_RST = COLOR_WIDTH'(BG_DEFAULT);

  logic                   hit;
  logic [COLOR_WIDTH-1:0] fg_sh, bg_sh;
  logic [COLOR_WIDTH-1:0] fg_d1, bg_d1, fg_d2, bg_d2;
  logic                   hit_d1, hit_d2;
  logic                   de_d1, de_d2, hs_d1, hs_d2, vs_d1, vs_d2;

  sign_addr_gen #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .POS_WIDTH  (POS_WIDTH),
    .SIGN_W     (SIGN_W),
    .SIGN_H     (SIGN_H)
  ) u_addr_gen (
    .clk           (clk),
    .rst_n         (rst_n),
    .frame_start_i (frame_start_i),
    .pix_x_i       (pix_x_i),
    .pix_y_i       (pix_y_i),
    .de_i          (de_i),
    .enable_i      (enable_i),
    .org_x_i       (org_x_i),
    .org_y_i       (org_y_i),
    .rom_addr_o    (rom_addr_o),
    .hit_o         (hit)
  );

  // Colour shadows load on frame_start_i; the colours then travel with the
  // pixel so a frame boundary inside the pipeline cannot recolour it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fg_sh  <= FG_RST;
      bg_sh  <= BG_RST;
      fg_d1  <= '0;
      bg_d1  <= '0;
      fg_d2  <= '0;
      bg_d2  <= '0;
      hit_d1 <= 1'b0;
      hit_d2 <= 1'b0;
      de_d1  <= 1'b0;
      de_d2  <= 1'b0;
      de_o   <= 1'b0;
      hs_d1  <= 1'b0;
      hs_d2  <= 1'b0;
      hs_o   <= 1'b0;
      vs_d1  <= 1'b0;
      vs_d2  <= 1'b0;
      vs_o   <= 1'b0;
      rgb_o  <= '0;
    end else begin
      if (frame_start_i) begin
        fg_sh <= fg_color_i;
        bg_sh <= bg_color_i;
      end
      // Stage 1: aligned with rom_addr_o.
      fg_d1  <= fg_sh;
      bg_d1  <= bg_sh;
      hit_d1 <= hit;
      de_d1  <= de_i;
      hs_d1  <= hs_i;
      vs_d1  <= vs_i;
      // Stage 2: aligned with rom_data_i.
      fg_d2  <= fg_d1;
      bg_d2  <= bg_d1;
      hit_d2 <= hit_d1;
      de_d2  <= de_d1;
      hs_d2  <= hs_d1;
      vs_d2  <= vs_d1;
      // Stage 3: output pixel, blanked outside the active area.
      de_o   <= de_d2;
      hs_o   <= hs_d2;
      vs_o   <= vs_d2;
      if (!de_d2)
        rgb_o <= '0;
      else if (hit_d2 && rom_data_i)
        rgb_o <= fg_d2;
      else
        rgb_o <= bg_d2;
    end
  end

endmodule

// File: tb/tb_sign_bitmap_render.sv
// Self-checking bench for sign_bitmap_render: a coordinate-level model of the
// sign window predicts every output, and a few literal values pin the model.
module tb_sign_bitmap_render;

  localparam int SW = 480;
  localparam int SH = 272;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        frame_start_i;
  logic [9:0]  pix_x_i, pix_y_i;
  logic        de_i, hs_i, vs_i;
  logic        enable_i;
  logic [9:0]  org_x_i, org_y_i;
  logic [15:0] fg_color_i, bg_color_i;
  logic [16:0] rom_addr_o;
  logic        rom_data_i;
  logic [15:0] rgb_o;
  logic        de_o, hs_o, vs_o;

  sign_bitmap_render dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .frame_start_i (frame_start_i),
    .pix_x_i       (pix_x_i),
    .pix_y_i       (pix_y_i),
    .de_i          (de_i),
    .hs_i          (hs_i),
    .vs_i          (vs_i),
    .enable_i      (enable_i),
    .org_x_i       (org_x_i),
    .org_y_i       (org_y_i),
    .fg_color_i    (fg_color_i),
    .bg_color_i    (bg_color_i),
    .rom_addr_o    (rom_addr_o),
    .rom_data_i    (rom_data_i),
    .rgb_o         (rgb_o),
    .de_o          (de_o),
    .hs_o          (hs_o),
    .vs_o          (vs_o)
  );

  always #5 clk = ~clk;

  // Sign ROM: random bitmap, 1-cycle registered read.
  bit rom_mem [0:(1<<17)-1];
  always @(posedge clk) rom_data_i <= rom_mem[rom_addr_o];

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Expected results for one sampled input cycle.
  typedef struct {
    int addr;   // rom_addr_o right after the sampling edge
    int rgb;    // rgb_o three edges later
    bit de, hs, vs;
    int pin_a;  // literal address expectation, -1 if none
    int pin_c;  // literal colour expectation, -1 if none
  } entry_t;

  function automatic entry_t zero_entry();
    entry_t e;
    e.addr = 0; e.rgb = 0; e.de = 0; e.hs = 0; e.vs = 0;
    e.pin_a = -1; e.pin_c = -1;
    return e;
  endfunction

  entry_t cur = zero_entry();

  // Model state: frame shadows and the last issued address.
  int m_en = 0, m_ox = 0, m_oy = 0, m_fg = 'hFFFF, m_bg = 0, m_addr = 0;

  // Literal pins for the current frame.
  int pin_x[8], pin_y[8], pin_a[8], pin_c[8];
  int pin_n = 0;

  task automatic add_pin(input int x, input int y, input int a, input int c);
    pin_x[pin_n] = x; pin_y[pin_n] = y; pin_a[pin_n] = a; pin_c[pin_n] = c;
    pin_n++;
  endtask

  task automatic model_reset();
    m_en = 0; m_ox = 0; m_oy = 0; m_fg = 'hFFFF; m_bg = 0; m_addr = 0;
  endtask

  // Present one input cycle, predict its outputs, advance to the next cycle.
  task automatic apply(input bit fs, input bit de, input bit hs, input bit vs,
                       input int x, input int y);
    entry_t e;
    bit hit;
    frame_start_i = fs; de_i = de; hs_i = hs; vs_i = vs;
    pix_x_i = 10'(x); pix_y_i = 10'(y);
    hit = !fs && (m_en != 0) && de && x >= m_ox && x < m_ox + SW
          && y >= m_oy && y < m_oy + SH;
    if (hit) m_addr = (y - m_oy) * SW + (x - m_ox);
    e = zero_entry();
    e.addr = m_addr;
    e.de = de; e.hs = hs; e.vs = vs;
    e.rgb = !de ? 0 : (hit && rom_mem[m_addr]) ? m_fg : m_bg;
    if (de)
      for (int i = 0; i < pin_n; i++)
        if (pin_x[i] == x && pin_y[i] == y) begin
          e.pin_a = pin_a[i];
          e.pin_c = pin_c[i];
        end
    cur = e;
    if (fs) begin
      m_en = int'(enable_i); m_ox = int'(org_x_i); m_oy = int'(org_y_i);
      m_fg = int'(fg_color_i); m_bg = int'(bg_color_i);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int x, input int y);
    frame_start_i = 0; de_i = 1; hs_i = 0; vs_i = 0;
    pix_x_i = 10'(x); pix_y_i = 10'(y);
    #2 rst_n = 0;
    #1;
    check("rst_addr", int'(rom_addr_o), 0);
    check("rst_rgb", int'(rgb_o), 0);
    check("rst_sideband", int'({de_o, hs_o, vs_o}), 0);
    model_reset();
    de_i = 0;
    cur = zero_entry();
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
  endtask

  // One frame: frame_start (separate cycle or on the first pixel), then h rows
  // of w pixels separated by random horizontal blanking.
  task automatic scan(input int w, input int h, input int fs_mode, input bit jitter,
                      input int chg_row, input int rst_x, input int rst_y);
    if (fs_mode == 0) apply(1, 0, 0, 1, 0, 0);
    for (int y = 0; y < h; y++) begin
      if (y > 0) begin
        int nb = int'($urandom_range(1, 3));
        for (int b = 0; b < nb; b++) apply(0, 0, 1, 0, 0, 0);
        if (jitter) begin
          enable_i = 1'($urandom); org_x_i = 10'($urandom); org_y_i = 10'($urandom);
          fg_color_i = 16'($urandom); bg_color_i = 16'($urandom);
        end
      end
      if (y == chg_row) fg_color_i = 16'hF800;
      for (int x = 0; x < w; x++) begin
        if (x == rst_x && y == rst_y) begin
          do_reset(x, y);
          return;
        end
        apply(fs_mode == 1 && x == 0 && y == 0, 1, 0, 0, x, y);
      end
    end
  endtask

  task automatic set_cfg(input bit en, input int ox, input int oy, input int fg, input int bg);
    enable_i = en; org_x_i = 10'(ox); org_y_i = 10'(oy);
    fg_color_i = 16'(fg); bg_color_i = 16'(bg);
    pin_n = 0;
  endtask

  // Compare process: sample the presented cycle at each rising edge, check on
  // the falling edge. rom_addr_o belongs to the newest sample, rgb/sidebands
  // to the one two edges older.
  initial begin
    entry_t pipe [3];
    for (int i = 0; i < 3; i++) pipe[i] = zero_entry();
    forever begin
      @(posedge clk);
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      pipe[0] = rst_n ? cur : zero_entry();
      @(negedge clk);
      if (!rst_n) begin
        for (int i = 0; i < 3; i++) pipe[i] = zero_entry();
      end else begin
        check("rom_addr", int'(rom_addr_o), pipe[0].addr);
        if (pipe[0].pin_a >= 0) check("pin_addr", int'(rom_addr_o), pipe[0].pin_a);
        check("rgb", int'(rgb_o), pipe[2].rgb);
        if (pipe[2].pin_c >= 0) check("pin_rgb", int'(rgb_o), pipe[2].pin_c);
        check("de", int'(de_o), int'(pipe[2].de));
        check("hs", int'(hs_o), int'(pipe[2].hs));
        check("vs", int'(vs_o), int'(pipe[2].vs));
      end
    end
  end

  initial begin
    for (int i = 0; i < (1 << 17); i++) rom_mem[i] = 1'($urandom);
    rom_mem[0] = 1'b1;
    rom_mem[101 * SW + 5] = 1'b1;

    rst_n = 0;
    frame_start_i = 0; de_i = 0; hs_i = 0; vs_i = 0;
    pix_x_i = '0; pix_y_i = '0;
    set_cfg(0, 0, 0, 'hFFFF, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    repeat (2) apply(0, 0, 0, 0, 0, 0);

    // Disabled: every active pixel is bg, address stays 0.
    set_cfg(0, 0, 0, 'hFFE0, 'h001F);
    add_pin(0, 0, 0, 'h001F);
    add_pin(10, 3, 0, 'h001F);
    add_pin(63, 7, 0, 'h001F);
    scan(64, 8, 0, 0, -1, -1, -1);

    // Full-width sign from origin 0,0 (top rows).
    set_cfg(1, 0, 0, 'hFFFF, 'h0000);
    add_pin(0, 0, 0, 'hFFFF);
    add_pin(1, 1, 481, -1);
    add_pin(479, 29, 29 * SW + 479, -1);
    scan(480, 30, 0, 0, -1, -1, -1);

    // Narrow, taller than the sign: bottom edge and row-base saturation.
    set_cfg(1, 0, 0, 'hABCD, 'h1234);
    add_pin(7, 271, 271 * SW + 7, -1);
    add_pin(0, 272, 271 * SW + 7, 'h1234);
    scan(8, 280, 0, 0, -1, -1, -1);

    // Offset window.
    set_cfg(1, 100, 50, 'hFFFF, 'h0F0F);
    add_pin(100, 50, 0, -1);
    add_pin(101, 50, 1, -1);
    add_pin(100, 51, 480, -1);
    add_pin(99, 50, -1, 'h0F0F);
    scan(160, 56, 0, 0, -1, -1, -1);

    // Right clip on an 800-wide scan.
    set_cfg(1, 300, 0, 'hFFFF, 'h0000);
    add_pin(300, 1, 480, -1);
    add_pin(779, 1, 959, -1);
    add_pin(799, 1, 959, -1);
    scan(800, 4, 0, 0, -1, -1, -1);

    // Mid-frame colour change takes effect only at the next frame start.
    set_cfg(1, 0, 0, 'h07E0, 'h0000);
    add_pin(5, 101, 101 * SW + 5, 'h07E0);
    scan(32, 104, 0, 0, 100, -1, -1);
    pin_n = 0;
    add_pin(0, 0, 0, 'hF800);
    scan(32, 4, 0, 0, -1, -1, -1);

    // Random frames with settings churn mid-frame and both frame-start styles.
    for (int f = 0; f < 6; f++) begin
      set_cfg(($urandom_range(0, 3) != 0), int'($urandom_range(0, 80)),
              int'($urandom_range(0, 20)), int'($urandom), int'($urandom));
      scan(int'($urandom_range(16, 96)), int'($urandom_range(4, 24)),
           int'($urandom_range(0, 1)), 1, -1, -1, -1);
    end

    // Reset mid-frame, then a clean restart.
    set_cfg(1, 0, 0, 'hFFFF, 'h0000);
    scan(201, 121, 0, 0, -1, 200, 120);
    repeat (3) apply(0, 0, 0, 0, 0, 0);
    pin_n = 0;
    add_pin(0, 0, 0, 'hFFFF);
    add_pin(1, 0, 1, -1);
    scan(32, 4, 0, 0, -1, -1, -1);

    repeat (4) apply(0, 0, 0, 0, 0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
